fwd_scoreboard: RTL

//  Parametrised operand-forwarding and load-use hazard unit for the pipelined core.

---
 rtl/fwd_scoreboard_pkg.sv | 34 +++
 rtl/fwd_scoreboard_match_prio.sv | 62 ++++++
 rtl/fwd_scoreboard.sv | 116 +++++++++++
 3 files changed

// File: rtl/fwd_scoreboard_pkg.sv
// ---------------------------------------------------------------------------
// fwd_scoreboard_pkg
//   Shared definitions for the forwarding / load-use hazard unit.
//   - FWD_SRC_REGFILE : select value meaning "take operand from register file"
//   - Entry layout    : {v, we, dst[REG_AW-1:0], ld}, with ld in bit 0
//   - sel_width()     : width of a per-operand bypass select for DEPTH stages
// ---------------------------------------------------------------------------
package fwd_scoreboard_pkg;

    localparam int FWD_SRC_REGFILE = 0;

    // Fixed low-order fields of a scoreboard entry
    localparam int ENT_LD_OFS  = 0;
    localparam int ENT_DST_OFS = 1;

    // Fields above dst move with the register-index width
    function automatic int ent_we_ofs(input int reg_aw);
        return reg_aw + 1;
    endfunction

    function automatic int ent_v_ofs(input int reg_aw);
        return reg_aw + 2;
    endfunction

    function automatic int ent_width(input int reg_aw);
        return reg_aw + 3;
    endfunction

    // Select encodes 0 = regfile, k+1 = entry[k], so DEPTH+1 codes are needed
    function automatic int sel_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fwd_scoreboard_match_prio.sv
// ---------------------------------------------------------------------------
// fwd_match_prio
//   Compares one decode source operand against every scoreboard entry and
//   produces the bypass select for the youngest matching stage, plus a flag
//   saying the match hit a load that is not yet forwardable.
// Ports
//   src_valid  in   operand is actually read
//   src_reg    in   operand register index
//   entries    in   flattened scoreboard, entry[k] at bits [k*EW +: EW]
//   sel        out  0 = regfile, k+1 = entry[k]
//   load_hit   out  operand matches a load in entry[k], k < LOAD_LAT
// ---------------------------------------------------------------------------
module fwd_match_prio
    import fwd_scoreboard_pkg::*;
#(
    parameter int REG_AW   = 3,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1,
    localparam int EW      = ent_width(REG_AW),
    localparam int SELW    = sel_width(DEPTH)
) (
    input  logic                  src_valid,
    input  logic [REG_AW-1:0]     src_reg,
    input  logic [DEPTH*EW-1:0]   entries,
    output logic [SELW-1:0]       sel,
    output logic                  load_hit
);

    localparam int WE_OFS = ent_we_ofs(REG_AW);
    localparam int V_OFS  = ent_v_ofs(REG_AW);

    logic [DEPTH-1:0] match;
    logic [DEPTH-1:0] is_load;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
            // Entries that do not write a register can never supply a value
            assign match[gi] = src_valid
                             & entries[gi*EW + V_OFS]
                             & entries[gi*EW + WE_OFS]
                             & (entries[gi*EW + ENT_DST_OFS +: REG_AW] == src_reg);
            assign is_load[gi] = entries[gi*EW + ENT_LD_OFS];
        end
    endgenerate

    always_comb begin
        sel      = SELW'(FWD_SRC_REGFILE);
        load_hit = 1'b0;
        // Walk oldest to youngest so the youngest match overwrites older ones
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (match[k]) begin
                sel = SELW'(k + 1);
            end
        end
        for (int k = 0; k < DEPTH; k++) begin
            if ((k < LOAD_LAT) && match[k] && is_load[k]) begin
                load_hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// ---------------------------------------------------------------------------
// fwd_scoreboard
//   Operand-forwarding and load-use hazard unit. Keeps a shifting scoreboard
//   of in-flight destinations (entry[0]=EX .. entry[DEPTH-1]=WB) and drives a
//   bypass select per decode operand. Raises stall on load-use; the stalled
//   instruction is replaced by a bubble while older entries keep draining.
// Ports
//   clk, rst      clock, synchronous active-high reset
//   issue_valid   decode instruction valid
//   issue_we      decode instruction writes a register
//   issue_dst     decode destination register
//   issue_load    decode instruction is a load
//   flush         kill the decode instruction (no insert, no stall)
//   src_valid     per-operand read enable
//   src_reg       per-operand register index, operand 0 in LSBs
//   fwd_sel       per-operand select, 0 = regfile, k+1 = entry[k]
//   stall         hold PC/IF/ID, bubble into EX
//   stall_cnt     saturating count of stall cycles (only with FWD_STATS_EN)
// Build option
//   FWD_STATS_EN  adds the stall_cnt port and its counter
// ---------------------------------------------------------------------------
module fwd_scoreboard
    import fwd_scoreboard_pkg::*;
#(
    parameter int REG_AW   = 3,
    parameter int NUM_SRC  = 2,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1,
    localparam int SELW    = sel_width(DEPTH),
    localparam int EW      = ent_width(REG_AW)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      issue_valid,
    input  logic                      issue_we,
    input  logic [REG_AW-1:0]         issue_dst,
    input  logic                      issue_load,
    input  logic                      flush,
    input  logic [NUM_SRC-1:0]        src_valid,
    input  logic [NUM_SRC*REG_AW-1:0] src_reg,
    output logic [NUM_SRC*SELW-1:0]   fwd_sel,
    output logic                      stall
`ifdef FWD_STATS_EN
    ,
    output logic [15:0]               stall_cnt
`endif
);

    logic [EW-1:0]       entry_reg [DEPTH];
    logic [EW-1:0]       entry0_next;
    logic [DEPTH*EW-1:0] entries_flat;
    logic [NUM_SRC-1:0]  load_hit;
    logic                insert;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_flat
            assign entries_flat[gi*EW +: EW] = entry_reg[gi];
        end

        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            fwd_match_prio #(
                .REG_AW   (REG_AW),
                .DEPTH    (DEPTH),
                .LOAD_LAT (LOAD_LAT)
            ) u_match (
                .src_valid (src_valid[gi]),
                .src_reg   (src_reg[gi*REG_AW +: REG_AW]),
                .entries   (entries_flat),
                .sel       (fwd_sel[gi*SELW +: SELW]),
                .load_hit  (load_hit[gi])
            );
        end
    endgenerate

    assign stall  = issue_valid & ~flush & (|load_hit);
    assign insert = issue_valid & ~flush & ~stall;

    // A stalled or flushed decode slot enters EX as a bubble (v=0)
    assign entry0_next = insert ? {1'b1, issue_we, issue_dst, issue_load} : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            entry_reg[0] <= '0;
        end else begin
            entry_reg[0] <= entry0_next;
        end
    end

    // Older entries shift every cycle, stall or not, so a load always drains
    generate
        for (genvar gi = 1; gi < DEPTH; gi++) begin : g_shift
            always_ff @(posedge clk) begin
                if (rst) begin
                    entry_reg[gi] <= '0;
                end else begin
                    entry_reg[gi] <= entry_reg[gi-1];
                end
            end
        end
    endgenerate

`ifdef FWD_STATS_EN
    logic [15:0] stall_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_reg <= '0;
        end else if (stall && (stall_cnt_reg != 16'hFFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_reg;
`endif

endmodule
